// File: rtl/wallace_multiplier_16x16.sv
// wallace_multiplier_16x16 -- unsigned 16x16 -> 32-bit registered multiplier.
//
// Partial products a[j]&b[i] are reduced column by column through six
// Wallace layers of full/half adders down to two rows, which a 32-bit
// carry-propagate adder then sums into the registered product.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset (clears every register)
//   a, b     16-bit unsigned operands, sampled every edge
//   product  32-bit registered a*b
//
// Build option: define WALLACE_MULT_PIPE_EN to register the two reduced
// rows ahead of the final adder (latency 2 instead of 1).

module wallace_fa (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ z;
    assign co = (x & y) | (x & z) | (y & z);
endmodule

module wallace_ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic co
);
    assign s  = x ^ y;
    assign co = x & y;
endmodule

module wallace_multiplier_16x16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] product
);
    localparam int N  = 16;
    localparam int W  = 32;
    localparam int NL = 6;

    // Bits a column of height h leaves in its own column / sends as carries.
    function automatic int own_n(input int h);
        return h / 3 + ((h % 3 != 0) ? 1 : 0);
    endfunction

    function automatic int cy_n(input int h);
        return h / 3 + ((h % 3 == 2) ? 1 : 0);
    endfunction

    // Height of column c at the input of layer l (layer 0 = raw partial products).
    function automatic int col_h(input int l, input int c);
        int h [W];
        int n [W];
        if (c < 0 || c >= W) return 0;
        for (int k = 0; k < W; k++)
            h[k] = (k < N) ? k + 1 : ((k < 2 * N - 1) ? 2 * N - 1 - k : 0);
        for (int s = 0; s < l; s++) begin
            for (int k = 0; k < W; k++)
                n[k] = own_n(h[k]) + ((k > 0) ? cy_n(h[k-1]) : 0);
            for (int k = 0; k < W; k++)
                h[k] = n[k];
        end
        return h[c];
    endfunction

    logic [W-1:0] row_s;
    logic [W-1:0] row_c;

    // Each column's input vector is ordered {carries from column c-1, own
    // outputs of column c}; the layer consumes it three bits at a time.
    for (genvar l = 0; l <= NL; l++) begin : g_lay
        for (genvar c = 0; c < W; c++) begin : g_col
            localparam int H  = col_h(l, c);
            localparam int HO = own_n(col_h(l - 1, c));
            localparam int HC = cy_n(col_h(l - 1, c - 1));
            if (H > 0) begin : g_nz
                logic [H-1:0] in;
                if (l == 0) begin : g_pp
                    for (genvar i = 0; i < N; i++) begin : g_i
                        if (c - i >= 0 && c - i < N) begin : g_t
                            assign in[i - ((c > N - 1) ? c - (N - 1) : 0)] = a[c-i] & b[i];
                        end
                    end
                end else begin : g_fwd
                    if (HO > 0) begin : g_o
                        assign in[HO-1:0] = g_lay[l-1].g_col[c].g_nz.g_red.o;
                    end
                    if (HC > 0) begin : g_c
                        assign in[H-1:HO] = g_lay[l-1].g_col[c-1].g_nz.g_red.g_cells.cy;
                    end
                end

                if (l < NL) begin : g_red
                    localparam int NC = cy_n(H);
                    localparam int NO = own_n(H);
                    logic [NO-1:0] o;
                    if (NC == 0) begin : g_pass
                        assign o[0] = in[0];
                    end else begin : g_cells
                        logic [NC-1:0] cy;
                        for (genvar g = 0; g < H / 3; g++) begin : g_fa
                            wallace_fa u_fa (
                                .x (in[3*g]),
                                .y (in[3*g+1]),
                                .z (in[3*g+2]),
                                .s (o[g]),
                                .co(cy[g])
                            );
                        end
                        if (H % 3 == 2) begin : g_ha
                            wallace_ha u_ha (
                                .x (in[H-2]),
                                .y (in[H-1]),
                                .s (o[H/3]),
                                .co(cy[H/3])
                            );
                        end
                        if (H % 3 == 1) begin : g_left
                            assign o[H/3] = in[H-1];
                        end
                        // Carries out of bit 31 carry no weight in a 32-bit product.
                        if (c == W - 1) begin : g_drop
                            logic [NC-1:0] unused_cy;
                            assign unused_cy = cy;
                        end
                    end
                end else begin : g_out
                    assign row_s[c] = in[0];
                    if (H > 1) begin : g_two
                        assign row_c[c] = in[1];
                    end else begin : g_one
                        assign row_c[c] = 1'b0;
                    end
                end
            end else if (l == NL) begin : g_zero
                assign row_s[c] = 1'b0;
                assign row_c[c] = 1'b0;
            end
        end
    end

`ifdef WALLACE_MULT_PIPE_EN
    logic [W-1:0] s_q;
    logic [W-1:0] c_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q     <= '0;
            c_q     <= '0;
            product <= '0;
        end else begin
            s_q     <= row_s;
            c_q     <= row_c;
            product <= s_q + c_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) product <= '0;
        else        product <= row_s + row_c;
    end
`endif

endmodule

// File: tb/tb_wallace_multiplier_16x16.sv
module tb_wallace_multiplier_16x16;
`ifdef WALLACE_MULT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] product;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit active = 1'b1;

    logic [31:0] exp_q [$];
    bit          hist_rst [$];
    logic [31:0] hist_p [$];

    wallace_multiplier_16x16 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .product(product)
    );

    always #5 clk = ~clk;

    // Reference: after edge k, product is a*b of the operands seen LAT-1
    // edges earlier, or 0 if any of those LAT edges had reset asserted.
    always @(posedge clk) begin
        logic [31:0] e;
        bit          z;
        if (active) begin
            hist_rst.push_back(!rst_n);
            hist_p.push_back(32'(a) * 32'(b));
            if (hist_rst.size() > LAT) begin
                void'(hist_rst.pop_front());
                void'(hist_p.pop_front());
            end
            z = (hist_rst.size() < LAT);
            foreach (hist_rst[i]) if (hist_rst[i]) z = 1'b1;
            e = z ? 32'h0 : hist_p[0];
            exp_q.push_back(e);
        end
    end

    // Monitor: one result per cycle, checked just after the edge.
    always @(posedge clk) begin
        logic [31:0] e;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (product !== e) begin
                errors++;
                $display("FAIL product cyc=%0d got=%h exp=%h", cyc, product, e);
            end
        end else if (active) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty cyc=%0d got=%h", cyc, product);
        end
    end

    task automatic drive(input bit r, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        rst_n = r;
        a     = x;
        b     = y;
    endtask

    logic [15:0] dir_a [0:8] = '{16'd5, 16'd91, 16'hCDCD, 16'hFFFF, 16'h0000,
                                 16'h0001, 16'h8000, 16'hFFFF, 16'h1234};
    logic [15:0] dir_b [0:8] = '{16'd3, 16'd44, 16'hBABA, 16'hFBFB, 16'hFFFF,
                                 16'h8001, 16'h8000, 16'hFFFF, 16'h0000};

    initial begin
        rst_n = 1'b0;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        // Reset held three edges with max operands present.
        repeat (2) drive(1'b0, 16'hFFFF, 16'hFFFF);
        drive(1'b1, 16'hFFFF, 16'hFFFF);
        // Directed pairs back-to-back, including corners.
        for (int i = 0; i < 9; i++) drive(1'b1, dir_a[i], dir_b[i]);
        // Random stream with a mid-stream reset pulse.
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000 || i == 5001)
                drive(1'b0, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
            else
                drive(1'b1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
        end
        // Operands changing between edges must not disturb the output.
        @(negedge clk);
        a = 16'h00FF;
        b = 16'h0101;
        #2 a = 16'hAAAA;
        #1 a = 16'h00FF;
        repeat (LAT + 2) drive(1'b1, 16'h00FF, 16'h0101);
        @(negedge clk);
        active = 1'b0;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wallace_multiplier_16x16.md
# wallace_multiplier_16x16

Unsigned 16×16-bit multiplier producing a full 32-bit product, built as a Wallace-tree partial-product reduction followed by a final carry-propagate adder. The result is registered, so the block is a clocked arithmetic leaf that datapath blocks instantiate wherever a single-issue, fixed-latency multiply is needed. It has no handshake: a new operand pair may be applied every cycle.

## Interface
- No parameters. Operand widths are fixed at 16 bits.
- `clk`  input  1  Rising-edge clock.
- `rst_n`  input  1  Reset. One clock; reset is synchronous and active-low.
- `a`  input  16  Multiplicand, unsigned.
- `b`  input  16  Multiplier, unsigned.
- `product`  output  32  Registered unsigned product, `a*b`.

## Operation
- Partial products:
  - 256 AND terms, `pp[i][j] = a[j] & b[i]`.
  - Each term has weight 2^(i+j).
- Reduction:
  - The block uses Wallace-style layers of full adders (3:2) and half adders (2:2).
  - Each layer processes every column, grouping bits in threes.
  - Reduction repeats until at most two rows remain (6 layers for 16 rows).
  - Carries feed the next column in the next layer.
- Final add:
  - A 32-bit carry-propagate adder sums the two remaining rows.
  - Any carry-out beyond bit 31 is discarded. It is provably zero, because the maximum product 0xFFFF×0xFFFF = 0xFFFE0001 fits in 32 bits.
- Arithmetic is unsigned only. No signed mode, rounding or saturation.
- The full-adder and half-adder cells are separate leaf modules inside the block's source.
- The output is exact for all 2^32 operand pairs.

## Timing
- Baseline latency is 1 cycle.
- `a` and `b` are sampled at rising edge N. `product` holds `a*b` from edge N until the next update.
- Throughput is 1 result per cycle, with no stalls.
- Reset:
  - Applies at a rising edge with `rst_n`=0.
  - `product` becomes 32'h0, along with every internal register.
  - Reset has priority over capture. Operands presented during reset cycles are discarded.
- Reset released mid-stream: the first valid result is the operands sampled at the first edge with `rst_n`=1.
- The path from `a`/`b` to register D is combinational. The implementation must not latch operands asynchronously.
- Operand changes between edges have no effect on `product`.

## Configuration
- Macro: `WALLACE_MULT_PIPE_EN`.
- Undefined (default):
  - Single register stage at `product`.
  - Latency 1.
- Defined:
  - An extra register stage captures the two reduced rows (sum row and carry row) between the Wallace tree and the final adder.
  - Latency becomes 2 cycles, and throughput is still 1 per cycle.
  - The pipeline register resets to 0 synchronously with `rst_n`. `product` reads 0 for the first 2 edges after reset release unless valid operands are present.
- Function is identical in both builds; only latency differs.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 edges with `a`=16'hFFFF, `b`=16'hFFFF. Required: `product`=32'h0 throughout. After release, `product`=32'hFFFE0001 at latency.
- **Small values:** `a`=5, `b`=3 → `product`=32'h0000000F after latency. Also `a`=91, `b`=44 → 32'h00000FA4 (4004).
- **Dense carries:** `a`=16'hCDCD, `b`=16'hBABA → 32'h961C78F2. Also `a`=16'hFFFF, `b`=16'hFBFB → 32'hFBFA0405.
- **Back-to-back:** apply the four pairs above on consecutive cycles. Required: the same four results appear on consecutive cycles in order, at the build's latency (1 default, 2 with `WALLACE_MULT_PIPE_EN`).
- **Corners:**
  - 0×16'hFFFF → 0
  - 1×16'h8001 → 32'h00008001
  - 16'h8000×16'h8000 → 32'h40000000
- **Random vs model:** ≥10,000 random pairs plus a mid-stream `rst_n` pulse. Required: every result equals the 32-bit unsigned `a*b` at the expected cycle, and is 0 during and immediately after reset.
